// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, optional parity, per-entry
// error flags and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n,
  input  logic                          rx_i,
  input  logic                          cfg_en,
  input  logic [15:0]                   cfg_clks_per_bit,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          rd_en_i,
  output logic                          rd_valid_o,
  output logic [DATA_W+1:0]             rd_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overrun_o,
  input  logic                          overrun_clr_i,
  output logic                          busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_W + 2;
  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_s;
  logic [15:0]             cpb_q, half, timer_q;
  logic                    par_en_q, par_odd_q;
  logic                    s_early_q, s_mid_q, maj;
  logic                    vote_done, wrap;
  logic [3:0]              bit_cnt_q;
  logic [DATA_W-1:0]       shreg_q;
  logic                    par_err_q, exp_par, wait_high_q;
  logic                    push;
  logic [EW-1:0]           push_data;

  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level_q;
  logic                    pop, full, wr_ok;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign half      = cpb_q >> 1;
  assign vote_done = (timer_q == half + 16'd1);
  assign wrap      = (timer_q == cpb_q - 16'd1);
  assign maj       = (s_early_q & s_mid_q) | (s_early_q & rx_s) | (s_mid_q & rx_s);
  assign exp_par   = par_odd_q ? ~(^shreg_q) : ^shreg_q;

  // Input synchroniser; resets to the idle (high) line level.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) sync_q <= '1;
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FSM next-state logic; disabling the receiver aborts any frame.
  always_comb begin
    state_d = state_q;
    if (!cfg_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (!rx_s && !wait_high_q) state_d = START;
        START:   if (vote_done && maj) state_d = IDLE;
                 else if (wrap)        state_d = DATA;
        DATA:    if (wrap && bit_cnt_q == LAST_BIT)
                   state_d = par_en_q ? PARITY : STOP;
        PARITY:  if (wrap) state_d = STOP;
        STOP:    if (vote_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: busy flag and the push strobe at the stop-bit vote.
  always_comb begin
    busy_o    = (state_q != IDLE);
    push      = cfg_en && (state_q == STOP) && vote_done;
    push_data = {par_err_q, ~maj, shreg_q};
  end

  // Receive datapath: config latch, bit timer, sampling, shift and flags.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cpb_q       <= 16'd4;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      timer_q     <= '0;
      s_early_q   <= 1'b1;
      s_mid_q     <= 1'b1;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_err_q   <= 1'b0;
      wait_high_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        cpb_q     <= (cfg_clks_per_bit < 16'd4) ? 16'd4 : cfg_clks_per_bit;
        par_en_q  <= cfg_parity_en;
        par_odd_q <= cfg_parity_odd;
        bit_cnt_q <= '0;
        par_err_q <= 1'b0;
      end
      if (state_q == IDLE || state_d == IDLE || wrap) timer_q <= '0;
      else                                            timer_q <= timer_q + 16'd1;
      if (timer_q == half - 16'd1) s_early_q <= rx_s;
      if (timer_q == half)         s_mid_q   <= rx_s;
      if (state_q == DATA) begin
        if (vote_done) shreg_q   <= {maj, shreg_q[DATA_W-1:1]};
        if (wrap)      bit_cnt_q <= bit_cnt_q + 4'd1;
      end
      if (state_q == PARITY && vote_done) par_err_q <= maj ^ exp_par;
      // After a framing error the line may still be low (break); re-arm only once it is high.
      if (push && !maj) wait_high_q <= 1'b1;
      else if (rx_s)    wait_high_q <= 1'b0;
    end
  end

  assign pop   = rd_en_i && (level_q != '0);
  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign wr_ok = push && (!full || pop);

  // FIFO storage.
  always_ff @(posedge wb_clk_i) begin
    if (wr_ok) mem[wr_ptr_q] <= push_data;
  end

  // FIFO pointers, level counter and sticky overrun flag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_ok, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (push && full && !pop) overrun_o <= 1'b1;
      else if (overrun_clr_i)   overrun_o <= 1'b0;
    end
  end

  assign rd_valid_o   = (level_q != '0);
  assign rd_data_o    = rd_valid_o ? mem[rd_ptr_q] : '0;
  assign fifo_level_o = level_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a buffered output. It replaces the single-byte receive path behind `io_in[5]` with runtime-programmable baud divisor, optional parity, 3-sample majority voting, and per-entry error flags. Frames are stored in a first-word-fall-through receive FIFO that the core or boot loader drains at its own pace. It sits between the pad input and the Wishbone/logic-analyser register space, clocked by the system clock.

## Interface
Parameters:
- `DATA_W`, 8, data bits per frame (5..8).
- `FIFO_DEPTH`, 16, receive FIFO entries (power of two, ≥2).
- `SYNC_STAGES`, 2, input synchroniser flops (≥2).

Ports:
- `wb_clk_i`  in  1  system clock; all logic is on the rising edge.
- `wb_rst_n`  in  1  asynchronous, active-low reset.
- `rx_i`  in  1  serial input, asynchronous to `wb_clk_i`, idles high.
- `cfg_en`  in  1  receiver enable.
- `cfg_clks_per_bit`  in  16  clocks per bit; values below 4 are treated as 4.
- `cfg_parity_en`  in  1  a parity bit follows the data bits.
- `cfg_parity_odd`  in  1  1 = odd parity, 0 = even parity.
- `rd_en_i`  in  1  pop the head entry; ignored when the FIFO is empty.
- `rd_valid_o`  out  1  FIFO not empty.
- `rd_data_o`  out  DATA_W+2  head entry `{parity_err, frame_err, data}`.
- `fifo_level_o`  out  $clog2(FIFO_DEPTH)+1  number of entries held.
- `overrun_o`  out  1  sticky flag: a frame was dropped because the FIFO was full.
- `overrun_clr_i`  in  1  clears `overrun_o`.
- `busy_o`  out  1  FSM is not in IDLE.

## Operation
- Input sync: `rx_i` passes through a SYNC_STAGES flop chain. All chain flops reset to 1.
- Bit timer: counts 0..`cpb`-1, where `cpb` is the clamped divisor. `half` = `cpb`>>1.
- Sampling: each bit is sampled at timer counts `half`-1, `half` and `half`+1. The bit value is the 2-of-3 majority.
- FSM states:
  - IDLE: a synced low level moves to START with the timer cleared.
  - START: if the majority is 1, it is a false start and the FSM returns to IDLE. Otherwise it moves to DATA at timer wrap.
  - DATA: DATA_W bits, LSB first, shifted in at each bit's vote. After the last bit it moves to PARITY if `cfg_parity_en`, else to STOP.
  - PARITY: `parity_err` = received bit ≠ the computed parity (even: XOR of the data; odd: its inverse).
  - STOP: `frame_err` = (stop vote == 0). The frame is pushed on the cycle the vote completes, and the FSM moves to IDLE at once. It does not wait out the stop bit, so back-to-back frames are caught.
- Config sampling: `cfg_*` are sampled in IDLE only. Changes mid-frame take effect on the next frame.
- `cfg_en` low: the FSM is forced to IDLE, any in-flight frame is discarded, and no pushes occur. FIFO contents and `overrun_o` are retained.
- A break (all-zero data, low stop bit) is stored as data 0 with `frame_err` = 1. The FSM then waits in IDLE for `rx` to return high before a new start bit can be detected.
- FIFO: uses DEPTH entries with a wrapping pointer plus a level counter.
  - Push while full and not popping: the frame is dropped, `overrun_o` is set, and the FIFO is unchanged.
  - Push and pop in the same cycle while full: both take effect and the level stays at DEPTH.
  - Push and pop in the same cycle while empty: only the push takes effect, because `rd_en_i` is ignored when empty.
  - Pop when empty: no effect.
- `overrun_o`: `overrun_clr_i` and a new overrun in the same cycle leave the flag set.
- Reset values: `rd_valid_o`=0, `rd_data_o`=0, `fifo_level_o`=0, `overrun_o`=0, `busy_o`=0, FSM=IDLE, timer=0.

## Timing
- Start detection latency: SYNC_STAGES+1 cycles from the `rx_i` falling edge to `busy_o`=1.
- Push latency: `rd_valid_o` rises and `rd_data_o` is valid one cycle after the edge on which the stop vote completes.
- `rd_data_o` is first-word-fall-through. After `rd_en_i` is registered, the next entry (or 0 when the FIFO becomes empty) appears the following cycle.
- `fifo_level_o` and `overrun_o` are registered and update one cycle after the push or pop event.
- Reset mid-frame: all state clears immediately. The next full frame after release is received correctly.

## Test plan
- Reset, then set `cpb`=217 at 25 MHz (115200 baud, 8N1) and send 0x13 → `rd_valid_o`=1, `rd_data_o`={0,0,0x13}, `fifo_level_o`=1.
- Send 0x13,0x00,0x00,0x00,0xFF,0x0F,0x00,0x00 back-to-back with no reads → level 8. Eight pops return the same bytes in order, all with error bits 0. The last pop drops `rd_valid_o`.
- Even parity, send 0xA5 with parity bit 1 (correct value is 0) → entry {1,0,0xA5}. Resend with parity 0 → entry {0,0,0xA5}.
- Stop bit driven low on 0x3C → entry {0,1,0x3C}. Then a 3-cycle low glitch in idle → `busy_o` pulses, no entry is pushed, level unchanged.
- FIFO_DEPTH=4, send 5 frames with no reads → level 4, `overrun_o`=1, 5th frame lost. Assert `overrun_clr_i` → 0. At full, a pop in the same cycle as a push → level stays 4 and the newest frame is retained.
- Assert `wb_rst_n`=0 during data bit 3 of a frame → all outputs return to reset values at once. Release, then send 0x5A → entry {0,0,0x5A}.
